if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction fetch stage; producer side of the IF->ID valid/ack handshake.
//  Fetches one 32-bit instruction at a time from instruction memory (single
//  outstanding request). Presents {instr, pc} to the decode stage and redirects
//  to pc_target_i on flush_i.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC fetched first after reset
//  PC_INC    4              byte increment between sequential fetches
// PORTS
//  clk          in   1   core clock; single clock domain
//  rstn_i       in   1   asynchronous reset, active-low
//  flush_i      in   1   redirect request: drop fetched or in-flight instruction, restart at pc_target_i
//  halt_i       in   1   freeze all state (core-wide halt)
//  pc_target_i  in   32  redirect target, sampled when flush_i=1
//  mem_req_o    out  1   fetch request; held high until mem_valid_i
//  mem_addr_o   out  32  fetch address; stable while mem_req_o=1
//  mem_valid_i  in   1   response strobe, one cycle, only while mem_req_o=1
//  mem_data_i   in   32  instruction word, valid with mem_valid_i
//  valid_o      out  1   instr_o/pc_o hold a valid instruction for decode
//  instr_o      out  32  fetched instruction
//  pc_o         out  32  address of instr_o
//  ack_i        in   1   decode consumed instr_o/pc_o this cycle
// BEHAVIOUR
//  Reset: state=IDLE, pc_q=RESET_PC, addr_q=RESET_PC, mem_req_o=0,
//   valid_o=0, instr_o=0, pc_o=0.
//  Output slot: valid_o/instr_o/pc_o come from register data_q.
//   - Held unchanged until ack_i=1. ack_i with valid_o=0 is ignored.
//   - The slot is free when !data_q.valid || ack_i.
//  FSM states: IDLE, REQ, DISCARD. mem_req_o=1 in REQ and DISCARD; mem_addr_o=addr_q.
//  IDLE:
//   - slot free && !flush_i -> addr_q<=pc_q; go to REQ (request visible next cycle).
//   - otherwise stay in IDLE.
//  REQ:
//   - mem_valid_i && !flush_i -> data_q<={1,mem_data_i,addr_q}; pc_q<=addr_q+PC_INC; go to IDLE.
//   - flush_i && mem_valid_i -> drop the response; go to IDLE.
//   - flush_i && !mem_valid_i -> go to DISCARD.
//   - neither -> wait in REQ.
//  DISCARD: wait for mem_valid_i, drop the word, go to IDLE; flush_i here only updates pc_q.
//  Invariant: a request is issued only while the slot is free, so the slot is
//   always empty when a response arrives; no overflow buffer is needed.
//  Throughput: at most 1 instruction per 2 cycles with zero-wait memory; latency
//   from slot-free to valid_o is 1 + memory wait cycles + 1.
//  flush_i, in any state:
//   - pc_q<={pc_target_i[31:2],2'b00}; the low bits are ignored.
//   - data_q.valid<=0, even if ack_i is asserted the same cycle.
//   - flush_i has priority over load and ack.
//  halt_i=1: no register updates, outputs hold their values. The system freezes
//   memory with the same halt, so mem_valid_i is never asserted during halt_i.
//  PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0.
//  Reset asserted mid-request: returns to IDLE immediately; the memory side is
//   reset by the same rstn_i.
// STRUCTURE
//  Core package holds:
//   - typedef enum logic [1:0] {IDLE,REQ,DISCARD} fetch_state_e.
//   - typedef struct packed {valid; instr[31:0]; pc[31:0]} fetch_data_t.
//  No sub-module: FSM, PC register and output register live in one module.
// TESTING
//  1. Reset, memory answers 1 cycle after req -> first mem_addr_o=RESET_PC;
//     valid_o=1, pc_o=0, instr_o=memory word.
//  2. Keep ack_i=0 for 5 cycles with valid_o=1 -> no new request;
//     valid_o/instr_o/pc_o stable; after ack_i the next addr_o is pc_o+4.
//  3. flush_i with pc_target_i=32'h100 while in REQ (memory wait 3) ->
//     old response dropped, valid_o stays 0, next mem_addr_o=32'h100.
//  4. flush_i and mem_valid_i in the same cycle -> word dropped;
//     next request at target; valid_o=0.
//  5. halt_i for 4 cycles with valid_o=1 and ack_i=1 -> nothing changes;
//     after halt drops, a single ack is consumed.
//  6. pc_target_i=32'hFFFF_FFFE -> fetch at 32'hFFFF_FFFC, then the
//     sequential fetch wraps to 32'h0000_0000.

Source files
------------

// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage_pkg
//  Description : Shared types and helpers for the instruction fetch stage.
//                The fetch FSM state encoding, the packed output-slot record
//                {valid, instr, pc}, and the word-align helper for redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

    localparam int c_XLEN = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic               valid;
        logic [c_XLEN-1:0]  instr;
        logic [c_XLEN-1:0]  pc;
    } fetch_data_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [c_XLEN-1:0] align_word(input logic [c_XLEN-1:0] addr);
        return addr & ~(c_XLEN'(3));
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage_if
//  Description : Bus bundle for the fetch stage. Carries both the
//                instruction-memory request/response channel and the IF->ID
//                valid/ack handshake.
//    mem_req_o   fetch request, held until mem_valid_i
//    mem_addr_o  fetch address, stable while mem_req_o
//    mem_valid_i one-cycle response strobe
//    mem_data_i  instruction word returned with mem_valid_i
//    valid_o     instr_o/pc_o hold an instruction for decode
//    instr_o     fetched instruction
//    pc_o        address of instr_o
//    ack_i       decode consumed the instruction this cycle
//  Modports    : master = fetch stage, slave = memory + decode environment
//  Revision    : 1.0 - initial release
// ============================================================================
interface if_stage_if import if_stage_pkg::*; ();

    logic               mem_req_o;
    logic [c_XLEN-1:0]  mem_addr_o;
    logic               mem_valid_i;
    logic [c_XLEN-1:0]  mem_data_i;
    logic               valid_o;
    logic [c_XLEN-1:0]  instr_o;
    logic [c_XLEN-1:0]  pc_o;
    logic               ack_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_valid_i,
        input  mem_data_i,
        output valid_o,
        output instr_o,
        output pc_o,
        input  ack_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_valid_i,
        output mem_data_i,
        input  valid_o,
        input  instr_o,
        input  pc_o,
        output ack_i
    );

endinterface
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction fetch stage. Issues one fetch at a time to
//                instruction memory and presents {instr, pc} to decode over
//                a valid/ack handshake. flush_i redirects to pc_target_i and
//                drops any fetched or in-flight word; halt_i freezes all state.
//  Ports       :
//    clk          core clock
//    rstn_i       asynchronous reset, active-low
//    flush_i      redirect request
//    halt_i       freeze all state
//    pc_target_i  redirect target, sampled with flush_i
//    bus          if_stage_if.master (memory channel + decode handshake)
//  Revision    : 1.0 - initial release
// ============================================================================
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [c_XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [c_XLEN-1:0] PC_INC   = 32'd4
) (
    input  wire logic               clk,
    input  wire logic               rstn_i,
    input  wire logic               flush_i,
    input  wire logic               halt_i,
    input  wire logic [c_XLEN-1:0]  pc_target_i,
    if_stage_if.master              bus
);

    fetch_state_e       r_state;
    fetch_state_e       w_state_nxt;
    logic [c_XLEN-1:0]  r_pc;       // next sequential fetch address
    logic [c_XLEN-1:0]  r_addr;     // address of the outstanding request
    fetch_data_t        r_data;     // output slot towards decode

    logic               w_slot_free;
    logic               w_issue;
    logic               w_load;

    // A new request is only launched when the slot will be empty by the time
    // the response returns, so the response always has somewhere to land.
    assign w_slot_free = !r_data.valid || bus.ack_i;
    assign w_issue     = (r_state == IDLE) && w_slot_free && !flush_i;
    assign w_load      = (r_state == REQ) && bus.mem_valid_i && !flush_i;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
        end else if (!halt_i) begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_issue) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                // A flushed request still owes us one response; DISCARD
                // swallows it unless it arrives in the flush cycle itself.
                if (flush_i) begin
                    w_state_nxt = bus.mem_valid_i ? IDLE : DISCARD;
                end else if (bus.mem_valid_i) begin
                    w_state_nxt = IDLE;
                end
            end
            DISCARD: begin
                if (bus.mem_valid_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.mem_req_o  = (r_state == REQ) || (r_state == DISCARD);
        bus.mem_addr_o = r_addr;
        bus.valid_o    = r_data.valid;
        bus.instr_o    = r_data.instr;
        bus.pc_o       = r_data.pc;
    end

    // ------------------------------------------------------------------
    // PC, request address and output slot
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_pc   <= RESET_PC;
            r_addr <= RESET_PC;
            r_data <= '0;
        end else if (!halt_i) begin
            if (flush_i) begin
                r_pc <= align_word(pc_target_i);
            end else if (w_load) begin
                r_pc <= r_addr + PC_INC;
            end

            if (w_issue) begin
                r_addr <= r_pc;
            end

            // Flush wins over both a load and a same-cycle ack.
            if (flush_i) begin
                r_data.valid <= 1'b0;
            end else if (w_load) begin
                r_data <= '{valid: 1'b1, instr: bus.mem_data_i, pc: r_addr};
            end else if (bus.ack_i) begin
                r_data.valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_stage
//  Description : Directed testbench for if_stage. A small memory model answers
//                requests after a programmable number of wait cycles with the
//                word 32'hC0DE_0000 | addr[15:0].
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    logic        clk;
    logic        rstn_i;
    logic        flush_i;
    logic        halt_i;
    logic [31:0] pc_target_i;

    int          n_cmp;
    int          n_err;
    int          mem_wait;
    int          mem_cnt;

    if_stage_if bus ();

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .PC_INC   (32'd4)
    ) u_dut (
        .clk         (clk),
        .rstn_i      (rstn_i),
        .flush_i     (flush_i),
        .halt_i      (halt_i),
        .pc_target_i (pc_target_i),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: acts on the falling edge so its strobe is settled well
    // before the rising edge that samples it.
    always @(negedge clk) begin
        if (!rstn_i) begin
            bus.mem_valid_i = 1'b0;
            mem_cnt         = 0;
        end else if (bus.mem_valid_i) begin
            bus.mem_valid_i = 1'b0;
        end else if (bus.mem_req_o) begin
            if (mem_cnt == mem_wait) begin
                bus.mem_valid_i = 1'b1;
                bus.mem_data_i  = 32'hC0DE_0000 | {16'h0000, bus.mem_addr_o[15:0]};
                mem_cnt         = 0;
            end else begin
                mem_cnt = mem_cnt + 1;
            end
        end else begin
            mem_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Sample and drive 1 time unit after the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_slot(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
        chk({tag, "_valid"}, {31'd0, bus.valid_o}, {31'd0, v});
        chk({tag, "_pc"},    bus.pc_o,    pc);
        chk({tag, "_instr"}, bus.instr_o, ins);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_cmp           = 0;
        n_err           = 0;
        mem_wait        = 0;
        mem_cnt         = 0;
        rstn_i          = 1'b0;
        flush_i         = 1'b0;
        halt_i          = 1'b0;
        pc_target_i     = 32'h0;
        bus.ack_i       = 1'b0;
        bus.mem_valid_i = 1'b0;
        bus.mem_data_i  = 32'h0;

        // ---------------- Reset state ----------------
        step();
        step();
        chk_slot("rst", 1'b0, 32'h0, 32'h0);
        chk("rst_req",  {31'd0, bus.mem_req_o}, 32'd0);
        chk("rst_addr", bus.mem_addr_o, 32'h0);

        // ---------------- 1: first fetch ----------------
        rstn_i = 1'b1;
        step();
        chk("t1_req",  {31'd0, bus.mem_req_o}, 32'd1);
        chk("t1_addr", bus.mem_addr_o, 32'h0);
        step();
        chk_slot("t1", 1'b1, 32'h0, 32'hC0DE_0000);
        chk("t1_req_drop", {31'd0, bus.mem_req_o}, 32'd0);

        // ---------------- 2: back-pressure ----------------
        for (int i = 0; i < 5; i++) begin
            step();
            chk_slot("t2_hold", 1'b1, 32'h0, 32'hC0DE_0000);
            chk("t2_noreq", {31'd0, bus.mem_req_o}, 32'd0);
        end
        bus.ack_i = 1'b1;
        step();
        bus.ack_i = 1'b0;
        chk("t2_req",   {31'd0, bus.mem_req_o}, 32'd1);
        chk("t2_addr",  bus.mem_addr_o, 32'h4);
        chk("t2_empty", {31'd0, bus.valid_o}, 32'd0);
        step();
        chk_slot("t2", 1'b1, 32'h4, 32'hC0DE_0004);

        // ---------------- 3: flush while waiting ----------------
        mem_wait  = 3;
        bus.ack_i = 1'b1;
        step();
        bus.ack_i   = 1'b0;
        chk("t3_addr", bus.mem_addr_o, 32'h8);
        flush_i     = 1'b1;
        pc_target_i = 32'h100;
        step();
        flush_i = 1'b0;
        chk("t3_discard_req", {31'd0, bus.mem_req_o}, 32'd1);
        chk("t3_valid", {31'd0, bus.valid_o}, 32'd0);
        begin
            int k;
            k = 0;
            while (!bus.mem_valid_i && k < 10) begin
                step();
                chk("t3_wait_valid", {31'd0, bus.valid_o}, 32'd0);
                k++;
            end
            chk("t3_timeout", {31'd0, bus.mem_valid_i}, 32'd1);
        end
        mem_wait = 0;
        step();
        chk("t3_dropped", {31'd0, bus.valid_o}, 32'd0);
        chk("t3_idle",    {31'd0, bus.mem_req_o}, 32'd0);
        step();
        chk("t3_req",    {31'd0, bus.mem_req_o}, 32'd1);
        chk("t3_target", bus.mem_addr_o, 32'h100);
        step();
        chk_slot("t3", 1'b1, 32'h100, 32'hC0DE_0100);

        // ---------------- 4: flush with response same cycle ----------------
        bus.ack_i = 1'b1;
        step();
        bus.ack_i = 1'b0;
        chk("t4_addr",   bus.mem_addr_o, 32'h104);
        chk("t4_strobe", {31'd0, bus.mem_valid_i}, 32'd1);
        flush_i     = 1'b1;
        pc_target_i = 32'h200;
        step();
        flush_i = 1'b0;
        chk("t4_dropped", {31'd0, bus.valid_o}, 32'd0);
        chk("t4_idle",    {31'd0, bus.mem_req_o}, 32'd0);
        step();
        chk("t4_target",  bus.mem_addr_o, 32'h200);
        chk("t4_req",     {31'd0, bus.mem_req_o}, 32'd1);
        step();
        chk_slot("t4", 1'b1, 32'h200, 32'hC0DE_0200);

        // ---------------- 5: halt with ack held ----------------
        halt_i    = 1'b1;
        bus.ack_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_slot("t5_halt", 1'b1, 32'h200, 32'hC0DE_0200);
            chk("t5_noreq", {31'd0, bus.mem_req_o}, 32'd0);
        end
        halt_i = 1'b0;
        step();
        bus.ack_i = 1'b0;
        chk("t5_consumed", {31'd0, bus.valid_o}, 32'd0);
        chk("t5_addr",     bus.mem_addr_o, 32'h204);
        step();
        chk_slot("t5", 1'b1, 32'h204, 32'hC0DE_0204);

        // ---------------- 6: unaligned target and wrap ----------------
        bus.ack_i   = 1'b1;
        flush_i     = 1'b1;
        pc_target_i = 32'hFFFF_FFFE;
        step();
        bus.ack_i = 1'b0;
        flush_i   = 1'b0;
        chk("t6_flushed", {31'd0, bus.valid_o}, 32'd0);
        step();
        chk("t6_addr", bus.mem_addr_o, 32'hFFFF_FFFC);
        step();
        chk_slot("t6_top", 1'b1, 32'hFFFF_FFFC, 32'hC0DE_FFFC);
        bus.ack_i = 1'b1;
        step();
        bus.ack_i = 1'b0;
        chk("t6_wrap_addr", bus.mem_addr_o, 32'h0);
        step();
        chk_slot("t6_wrap", 1'b1, 32'h0, 32'hC0DE_0000);

        // ---------------- Reset mid-request ----------------
        bus.ack_i = 1'b1;
        step();
        bus.ack_i = 1'b0;
        chk("rq_addr", bus.mem_addr_o, 32'h4);
        rstn_i = 1'b0;
        #1;
        chk("rq_req",   {31'd0, bus.mem_req_o}, 32'd0);
        chk("rq_valid", {31'd0, bus.valid_o}, 32'd0);
        step();
        rstn_i = 1'b1;
        step();
        chk("rq_restart", bus.mem_addr_o, 32'h0);
        chk("rq_restart_req", {31'd0, bus.mem_req_o}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
